shift_unit: RTL and testbench



---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_step.sv | 50 +++++
 rtl/shift_unit.sv | 108 ++++++++++
 tb/tb_shift_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared types and constants for the iterative shifter and the register file
// it feeds.
//   shift_op_t    : shift/rotate operation encoding (matches the 2-bit op port)
//   shift_state_t : control states of shift_unit
//   DATA_W        : datapath width shared with the register file
//   REG_PW        : register address pointer width shared with the register file
// ---------------------------------------------------------------------------
package shift_pkg;

   localparam int DATA_W = 8;
   localparam int REG_PW = 3;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } shift_op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_WB    = 2'b10
   } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Purely combinational single-bit shift/rotate step.
// Ports:
//   op     : operation (SLL, SRL, SRA, ROL)
//   d      : current working value
//   next_d : value after one step
//   carry  : bit shifted or rotated out by this step
// ---------------------------------------------------------------------------
module shift_step
   import shift_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  shift_op_t      op,
   input  logic [W-1:0]   d,
   output logic [W-1:0]   next_d,
   output logic           carry
);

   // Left-going operations lose the MSB, right-going ones lose the LSB.
   // SRA replicates the sign bit; ROL feeds the MSB back into bit 0.
   always_comb begin
      next_d = d;
      carry  = 1'b0;
      case (op)
         OP_SLL: begin
            carry  = d[W-1];
            next_d = {d[W-2:0], 1'b0};
         end
         OP_SRL: begin
            carry  = d[0];
            next_d = {1'b0, d[W-1:1]};
         end
         OP_SRA: begin
            carry  = d[0];
            next_d = {d[W-1], d[W-1:1]};
         end
         OP_ROL: begin
            carry  = d[W-1];
            next_d = {d[W-2:0], d[W-1]};
         end
         default: begin
            carry  = 1'b0;
            next_d = d;
         end
      endcase
   end

endmodule

// File: rtl/shift_unit.sv
// ---------------------------------------------------------------------------
// shift_unit
// Iterative shifter in front of the register file write port. Accepts one
// command in IDLE, performs one single-bit step per clock, then presents a
// one-cycle write-back beat.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : command strobe, sampled only in IDLE
//   op          : 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   operand     : value to shift
//   amount      : number of single-bit steps (0 goes straight to write-back)
//   destAddr    : register-file destination for the result
//   busy        : high while shifting or presenting the write-back beat
//   writeEnable : one-cycle write-back strobe
//   writeAddr   : latched destAddr
//   dataOut     : working/result register
//   scryOut     : last bit shifted out (0 when amount was 0)
//   ngtvOut     : sign bit of dataOut
//   zeroOut     : dataOut is all zeros
// ---------------------------------------------------------------------------
module shift_unit
   import shift_pkg::*;
#(
   parameter int pw = REG_PW,
   parameter int W  = DATA_W,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [W-1:0]  operand,
   input  logic [AW-1:0] amount,
   input  logic [pw-1:0] destAddr,
   output logic          busy,
   output logic          writeEnable,
   output logic [pw-1:0] writeAddr,
   output logic [W-1:0]  dataOut,
   output logic          scryOut,
   output logic          ngtvOut,
   output logic          zeroOut
);

   shift_state_t  state;
   shift_op_t     op_q;
   logic [AW-1:0] count;
   logic          scry;
   logic [W-1:0]  step_d;
   logic          step_carry;

   shift_step #(.W(W)) u_step (
      .op     (op_q),
      .d      (dataOut),
      .next_d (step_d),
      .carry  (step_carry)
   );

   // Control and datapath registers. A command is only taken in IDLE, so a
   // start during SHIFT or WB is simply dropped. The step whose count is 1
   // is the last one and hands over to the write-back beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= OP_SLL;
         count     <= '0;
         scry      <= 1'b0;
         dataOut   <= '0;
         writeAddr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  dataOut   <= operand;
                  op_q      <= shift_op_t'(op);
                  writeAddr <= destAddr;
                  count     <= amount;
                  scry      <= 1'b0;
                  state     <= (amount != '0) ? S_SHIFT : S_WB;
               end
            end
            S_SHIFT: begin
               dataOut <= step_d;
               scry    <= step_carry;
               count   <= count - 1'b1;
               if (count == AW'(1)) begin
                  state <= S_WB;
               end
            end
            S_WB: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Flags follow dataOut directly so they hold along with it in IDLE.
   always_comb begin
      busy        = (state != S_IDLE);
      writeEnable = (state == S_WB);
      scryOut     = scry;
      ngtvOut     = dataOut[W-1];
      zeroOut     = (dataOut == '0);
   end

endmodule

// File: tb/tb_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_unit
// Directed testbench for shift_unit with hand-computed expected results.
// ---------------------------------------------------------------------------
module tb_shift_unit;

   localparam int PW = 3;
   localparam int W  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  operand = '0;
   logic [AW-1:0] amount = '0;
   logic [PW-1:0] destAddr = '0;
   logic          busy;
   logic          writeEnable;
   logic [PW-1:0] writeAddr;
   logic [W-1:0]  dataOut;
   logic          scryOut;
   logic          ngtvOut;
   logic          zeroOut;

   int total = 0;
   int bad   = 0;
   int beats = 0;

   shift_unit #(.pw(PW), .W(W), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .operand     (operand),
      .amount      (amount),
      .destAddr    (destAddr),
      .busy        (busy),
      .writeEnable (writeEnable),
      .writeAddr   (writeAddr),
      .dataOut     (dataOut),
      .scryOut     (scryOut),
      .ngtvOut     (ngtvOut),
      .zeroOut     (zeroOut)
   );

   always #5 clk = ~clk;

   // Counts write-back beats seen by the register file on its capture edge.
   always @(posedge clk) begin
      if (writeEnable === 1'b1) beats++;
   end

   typedef struct {
      logic [1:0]    o;
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      logic [PW-1:0] addr;
      logic [W-1:0]  rd;
      logic          rc;
   } vec_t;

   // Drives one command so that it is sampled on the next rising edge.
   task automatic send_cmd(input logic [1:0] o, input logic [W-1:0] d,
                           input logic [AW-1:0] a, input logic [PW-1:0] addr);
      op       = o;
      operand  = d;
      amount   = a;
      destAddr = addr;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      total++;
      if ({busy, writeEnable, writeAddr, dataOut, scryOut, ngtvOut, zeroOut} !== {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL reset_state got busy=%b we=%b addr=%0d data=%h scry=%b ngtv=%b zero=%b want 0 0 0 00 0 0 1",
                  busy, writeEnable, writeAddr, dataOut, scryOut, ngtvOut, zeroOut);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, writeEnable, dataOut, zeroOut} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
         bad++;
         $display("[TB] FAIL idle_after_reset got busy=%b we=%b data=%h zero=%b want 0 0 00 1",
                  busy, writeEnable, dataOut, zeroOut);
      end
   endtask

   task automatic test_shift_ops();
      vec_t vecs[7];
      vecs[0] = '{2'b00, 8'h81, 3'd1, 3'd5, 8'h02, 1'b1};
      vecs[1] = '{2'b10, 8'h80, 3'd3, 3'd2, 8'hF0, 1'b0};
      vecs[2] = '{2'b01, 8'h01, 3'd1, 3'd7, 8'h00, 1'b1};
      vecs[3] = '{2'b11, 8'h81, 3'd1, 3'd1, 8'h03, 1'b1};
      vecs[4] = '{2'b00, 8'hFF, 3'd7, 3'd3, 8'h80, 1'b1};
      vecs[5] = '{2'b10, 8'h40, 3'd7, 3'd4, 8'h00, 1'b1};
      vecs[6] = '{2'b11, 8'h96, 3'd7, 3'd6, 8'h4B, 1'b1};
      for (int i = 0; i < 7; i++) begin
         int n;
         n = int'(vecs[i].a);
         @(negedge clk);
         send_cmd(vecs[i].o, vecs[i].d, vecs[i].a, vecs[i].addr);
         for (int c = 0; c <= n + 1; c++) begin
            @(negedge clk);
            total++;
            if (busy !== (c <= n) || writeEnable !== (c == n)) begin
               bad++;
               $display("[TB] FAIL ops_timing vec=%0d cycle=%0d got busy=%b we=%b want busy=%b we=%b",
                        i, c, busy, writeEnable, (c <= n), (c == n));
            end
            if (c >= n) begin
               total++;
               if (dataOut !== vecs[i].rd || writeAddr !== vecs[i].addr || scryOut !== vecs[i].rc ||
                   ngtvOut !== vecs[i].rd[W-1] || zeroOut !== (vecs[i].rd == 8'h00)) begin
                  bad++;
                  $display("[TB] FAIL ops_result vec=%0d cycle=%0d got data=%h addr=%0d scry=%b ngtv=%b zero=%b want data=%h addr=%0d scry=%b ngtv=%b zero=%b",
                           i, c, dataOut, writeAddr, scryOut, ngtvOut, zeroOut,
                           vecs[i].rd, vecs[i].addr, vecs[i].rc, vecs[i].rd[W-1], (vecs[i].rd == 8'h00));
               end
            end
         end
      end
   endtask

   task automatic test_zero_amount();
      int b0;
      @(negedge clk);
      b0 = beats;
      send_cmd(2'b00, 8'h7F, 3'd0, 3'd4);
      // Second command held during the write-back beat must be ignored.
      op = 2'b01; operand = 8'h55; amount = 3'd0; destAddr = 3'd1; start = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, writeEnable, dataOut, writeAddr, scryOut, ngtvOut, zeroOut} !== {1'b1, 1'b1, 8'h7F, 3'd4, 1'b0, 1'b0, 1'b0}) begin
         bad++;
         $display("[TB] FAIL zero_amount_wb got busy=%b we=%b data=%h addr=%0d scry=%b ngtv=%b zero=%b want 1 1 7f 4 0 0 0",
                  busy, writeEnable, dataOut, writeAddr, scryOut, ngtvOut, zeroOut);
      end
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (beats - b0 !== 1 || dataOut !== 8'h7F || writeAddr !== 3'd4) begin
         bad++;
         $display("[TB] FAIL zero_amount_ignore got beats=%0d data=%h addr=%0d want beats=1 data=7f addr=4",
                  beats - b0, dataOut, writeAddr);
      end
   endtask

   task automatic test_busy_ignore();
      int b0;
      @(negedge clk);
      b0 = beats;
      send_cmd(2'b00, 8'h01, 3'd3, 3'd0);
      op = 2'b00; operand = 8'hAA; amount = 3'd0; destAddr = 3'd7; start = 1'b1;
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(negedge clk);
      total++;
      if (beats - b0 !== 1 || dataOut !== 8'h08 || writeAddr !== 3'd0 || scryOut !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL busy_ignore got beats=%0d data=%h addr=%0d scry=%b busy=%b want beats=1 data=08 addr=0 scry=0 busy=0",
                  beats - b0, dataOut, writeAddr, scryOut, busy);
      end
   endtask

   task automatic test_reset_mid();
      int b0;
      int c;
      @(negedge clk);
      b0 = beats;
      send_cmd(2'b00, 8'hFF, 3'd7, 3'd3);
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      total++;
      if ({busy, writeEnable, writeAddr, dataOut, scryOut, ngtvOut, zeroOut} !== {1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("[TB] FAIL reset_mid got busy=%b we=%b addr=%0d data=%h scry=%b ngtv=%b zero=%b want 0 0 0 00 0 0 1",
                  busy, writeEnable, writeAddr, dataOut, scryOut, ngtvOut, zeroOut);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (beats !== b0) begin
         bad++;
         $display("[TB] FAIL reset_drop got beats=%0d want 0", beats - b0);
      end
      send_cmd(2'b01, 8'hF0, 3'd5, 3'd6);
      c = 0;
      @(negedge clk);
      while (writeEnable !== 1'b1 && c < 20) begin
         c++;
         @(negedge clk);
      end
      total++;
      if (c !== 5 || dataOut !== 8'h07 || scryOut !== 1'b1 || writeAddr !== 3'd6) begin
         bad++;
         $display("[TB] FAIL reset_recover got wait=%0d data=%h scry=%b addr=%0d want wait=5 data=07 scry=1 addr=6",
                  c, dataOut, scryOut, writeAddr);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      send_cmd(2'b11, 8'h01, 3'd0, 3'd2);
      @(negedge clk);
      total++;
      if (writeEnable !== 1'b1 || dataOut !== 8'h01 || writeAddr !== 3'd2) begin
         bad++;
         $display("[TB] FAIL b2b_first got we=%b data=%h addr=%0d want we=1 data=01 addr=2",
                  writeEnable, dataOut, writeAddr);
      end
      @(posedge clk);
      #1;
      op = 2'b10; operand = 8'h80; amount = 3'd0; destAddr = 3'd3; start = 1'b1;
      @(negedge clk);
      total++;
      if (writeEnable !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_gap got we=%b busy=%b want we=0 busy=0", writeEnable, busy);
      end
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      total++;
      if (writeEnable !== 1'b1 || dataOut !== 8'h80 || writeAddr !== 3'd3 || ngtvOut !== 1'b1 || scryOut !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_second got we=%b data=%h addr=%0d ngtv=%b scry=%b want we=1 data=80 addr=3 ngtv=1 scry=0",
                  writeEnable, dataOut, writeAddr, ngtvOut, scryOut);
      end
   endtask

   initial begin
      test_reset();
      test_shift_ops();
      test_zero_amount();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
